// File: rtl/median_scan_ctrl_if.sv
// Host/pipeline-facing signal bundle for median_scan_ctrl.
// The controller drives through the master modport; the host/pipeline side uses slave.
interface median_scan_ctrl_if #(
  parameter int unsigned AW = 6
);
  logic          Start;
  logic          Stall;
  logic          Busy;
  logic          Done;
  logic          RD_en;
  logic [AW-1:0] RD_row;
  logic [AW-1:0] RD_col;
  logic [3:0]    Tap;
  logic          PX_valid;
  logic [AW-1:0] PX_row;
  logic [AW-1:0] PX_col;
  logic          Border;

  modport master (
    input  Start, Stall,
    output Busy, Done, RD_en, RD_row, RD_col, Tap,
           PX_valid, PX_row, PX_col, Border
  );

  modport slave (
    output Start, Stall,
    input  Busy, Done, RD_en, RD_row, RD_col, Tap,
           PX_valid, PX_row, PX_col, Border
  );
endinterface

// File: rtl/median_scan_ctrl.sv
// Raster-scan sequencer for the pipelined 3x3 median filter: window reads, pixel tags, drain/Done.
// Define BORDER_COPY_EN to issue only the centre read (tap 4) for edge pixels.
module median_scan_ctrl #(
  parameter int unsigned IMG_H    = 64,
  parameter int unsigned IMG_W    = 64,
  parameter int unsigned AW       = 6,
  parameter int unsigned PIPE_LAT = 4
) (
  input logic                Clock,
  input logic                Resetn,
  median_scan_ctrl_if.master bus
);

`ifdef BORDER_COPY_EN
  localparam bit BORDER_COPY = 1'b1;
`else
  localparam bit BORDER_COPY = 1'b0;
`endif

  localparam int unsigned   DW         = $clog2(PIPE_LAT + 1);
  localparam logic [AW-1:0] LAST_ROW   = AW'(IMG_H - 1);
  localparam logic [AW-1:0] LAST_COL   = AW'(IMG_W - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_LAT);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] row_q, row_d, col_q, col_d;
  logic [3:0]    tap_q, tap_d;
  logic [DW-1:0] cnt_q, cnt_d;

  logic          issue;
  logic          busy_q, busy_d, done_q, done_d;
  logic          rd_en_q, rd_en_d, pxv_q, pxv_d, border_q, border_d;
  logic [AW-1:0] rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic [AW-1:0] px_row_q, px_row_d, px_col_q, px_col_d;

  function automatic logic on_edge(input logic [AW-1:0] r, input logic [AW-1:0] c);
    return (r == '0) || (r == LAST_ROW) || (c == '0) || (c == LAST_COL);
  endfunction

  function automatic logic [3:0] first_tap(input logic [AW-1:0] r, input logic [AW-1:0] c);
    return (BORDER_COPY && on_edge(r, c)) ? 4'd4 : 4'd0;
  endfunction

  function automatic logic final_tap(input logic [3:0] t, input logic [AW-1:0] r,
                                     input logic [AW-1:0] c);
    return (BORDER_COPY && on_edge(r, c)) ? (t == 4'd4) : (t == 4'd8);
  endfunction

  // Edge replication by saturating the +/-1 step instead of signed add-then-clamp;
  // identical result and never overflows when the image spans the full address range.
  function automatic logic [AW-1:0] clamp_row(input logic [AW-1:0] r, input logic [3:0] t);
    if (t < 4'd3) return (r == '0) ? r : r - 1'b1;
    if (t > 4'd5) return (r == LAST_ROW) ? r : r + 1'b1;
    return r;
  endfunction

  function automatic logic [AW-1:0] clamp_col(input logic [AW-1:0] c, input logic [3:0] t);
    case (t)
      4'd0, 4'd3, 4'd6: return (c == '0) ? c : c - 1'b1;
      4'd2, 4'd5, 4'd8: return (c == LAST_COL) ? c : c + 1'b1;
      default:          return c;
    endcase
  endfunction

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      tap_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      pxv_q    <= 1'b0;
      border_q <= 1'b0;
      rd_row_q <= '0;
      rd_col_q <= '0;
      px_row_q <= '0;
      px_col_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      tap_q    <= tap_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      pxv_q    <= pxv_d;
      border_q <= border_d;
      rd_row_q <= rd_row_d;
      rd_col_q <= rd_col_d;
      px_row_q <= px_row_d;
      px_col_q <= px_col_d;
    end
  end

  // row_q/col_q/tap_q always describe the read currently presented on the outputs.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tap_d   = tap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = FETCH;
          row_d   = '0;
          col_d   = '0;
          tap_d   = first_tap('0, '0);
        end
      end
      FETCH: begin
        if (!bus.Stall) begin
          if (!final_tap(tap_q, row_q, col_q)) begin
            tap_d = tap_q + 4'd1;
          end else if (row_q == LAST_ROW && col_q == LAST_COL) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            tap_d = first_tap(row_d, col_d);
          end
        end
      end
      DRAIN: begin
        if (!bus.Stall) begin
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue    = (state_q == IDLE && bus.Start) ||
               (state_q == FETCH && !bus.Stall && state_d == FETCH);
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_en_d  = 1'b0;
    pxv_d    = 1'b0;
    border_d = 1'b0;
    rd_row_d = rd_row_q;
    rd_col_d = rd_col_q;
    px_row_d = px_row_q;
    px_col_d = px_col_q;
    if (issue) begin
      rd_en_d  = 1'b1;
      rd_row_d = clamp_row(row_d, tap_d);
      rd_col_d = clamp_col(col_d, tap_d);
      if (final_tap(tap_d, row_d, col_d)) begin
        pxv_d    = 1'b1;
        px_row_d = row_d;
        px_col_d = col_d;
        border_d = on_edge(row_d, col_d);
      end
    end
    if (state_q == IDLE && bus.Start)     busy_d = 1'b1;
    if (state_q == DONE)                  busy_d = 1'b0;
    if (state_q == DRAIN && state_d == DONE) done_d = 1'b1;
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.RD_en    = rd_en_q;
  assign bus.RD_row   = rd_row_q;
  assign bus.RD_col   = rd_col_q;
  assign bus.Tap      = tap_q;
  assign bus.PX_valid = pxv_q;
  assign bus.PX_row   = px_row_q;
  assign bus.PX_col   = px_col_q;
  assign bus.Border   = border_q;

endmodule

// File: tb/tb_median_scan_ctrl.sv
// Self-checking bench for median_scan_ctrl on a 4x4 image (AW=2 covers the full address range).
// Honours BORDER_COPY_EN when the design is built with it.
module tb_median_scan_ctrl;
  localparam int unsigned H  = 4;
  localparam int unsigned W  = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned PL = 4;
`ifdef BORDER_COPY_EN
  localparam bit BC        = 1'b1;
  localparam int EXP_READS = 48;
`else
  localparam bit BC        = 1'b0;
  localparam int EXP_READS = 144;
`endif

  typedef struct {
    int row;
    int col;
    int tap;
    int pr;
    int pc;
    bit pxv;
    bit brd;
  } rd_t;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  rd_t  exp_q[$];

  median_scan_ctrl_if #(.AW(AW)) bus_if ();

  median_scan_ctrl #(
    .IMG_H   (H),
    .IMG_W   (W),
    .AW      (AW),
    .PIPE_LAT(PL)
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus_if)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // Reference: every read of a frame in raster order, derived directly from the window rules.
  function automatic void build_model();
    rd_t e;
    bit  brd;
    exp_q.delete();
    for (int r = 0; r < int'(H); r++) begin
      for (int c = 0; c < int'(W); c++) begin
        brd = (r == 0) || (r == int'(H) - 1) || (c == 0) || (c == int'(W) - 1);
        if (BC && brd) begin
          e = '{row: r, col: c, tap: 4, pr: r, pc: c, pxv: 1'b1, brd: 1'b1};
          exp_q.push_back(e);
        end else begin
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              e.row = clampi(r + dr, int'(H) - 1);
              e.col = clampi(c + dc, int'(W) - 1);
              e.tap = (dr + 1) * 3 + (dc + 1);
              e.pr  = r;
              e.pc  = c;
              e.pxv = (e.tap == 8);
              e.brd = (e.tap == 8) && brd;
              exp_q.push_back(e);
            end
          end
        end
      end
    end
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"},   32'(bus_if.Busy),     32'd0);
    check({pfx, "_done"},   32'(bus_if.Done),     32'd0);
    check({pfx, "_rd_en"},  32'(bus_if.RD_en),    32'd0);
    check({pfx, "_rd_row"}, 32'(bus_if.RD_row),   32'd0);
    check({pfx, "_rd_col"}, 32'(bus_if.RD_col),   32'd0);
    check({pfx, "_tap"},    32'(bus_if.Tap),      32'd0);
    check({pfx, "_pxv"},    32'(bus_if.PX_valid), 32'd0);
    check({pfx, "_px_row"}, 32'(bus_if.PX_row),   32'd0);
    check({pfx, "_px_col"}, 32'(bus_if.PX_col),   32'd0);
    check({pfx, "_border"}, 32'(bus_if.Border),   32'd0);
  endtask

  // mode 0: no stall; 1: one 3-cycle stall at tap 5 mid-frame; 2: random stall.
  // noise: random Start pulses during the frame and on the Done cycle.
  task automatic run_frame(input int mode, input bit noise);
    rd_t           e;
    int            cyc, stalls, burst, reads;
    bit            stall_prev, done_seen, armed, exp_rd;
    logic [3:0]    last_tap;
    logic [AW-1:0] last_row, last_col;
    cyc = 0; stalls = 0; burst = 0; reads = 0;
    stall_prev = 1'b0; done_seen = 1'b0; armed = (mode == 1);
    last_tap = '0; last_row = '0; last_col = '0;
    build_model();
    @(negedge Clock);
    bus_if.Start = 1'b1;
    bus_if.Stall = (mode == 2) ? ($urandom_range(0, 1) == 0) : 1'b0;
    while (!done_seen && cyc < 4000) begin
      @(negedge Clock);
      cyc++;
      bus_if.Start = 1'b0;
      check("busy", 32'(bus_if.Busy), 32'd1);
      exp_rd = (exp_q.size() != 0) && (cyc == 1 || !stall_prev);
      if (stall_prev && cyc > 1 && exp_q.size() != 0) begin
        check("stall_tap_hold", 32'(bus_if.Tap),    32'(last_tap));
        check("stall_row_hold", 32'(bus_if.RD_row), 32'(last_row));
        check("stall_col_hold", 32'(bus_if.RD_col), 32'(last_col));
      end
      check("rd_en", 32'(bus_if.RD_en), 32'(exp_rd));
      if (bus_if.RD_en === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        reads++;
        check("rd_row",   32'(bus_if.RD_row),   e.row);
        check("rd_col",   32'(bus_if.RD_col),   e.col);
        check("tap",      32'(bus_if.Tap),      e.tap);
        check("px_valid", 32'(bus_if.PX_valid), 32'(e.pxv));
        check("border",   32'(bus_if.Border),   32'(e.brd));
        if (e.pxv) begin
          check("px_row", 32'(bus_if.PX_row), e.pr);
          check("px_col", 32'(bus_if.PX_col), e.pc);
        end
      end else begin
        check("px_valid_idle", 32'(bus_if.PX_valid), 32'd0);
      end
      if (bus_if.Done === 1'b1) begin
        done_seen = 1'b1;
        check("done_cycle", cyc, 2 + EXP_READS + int'(PL) + stalls);
        check("read_count", reads, EXP_READS);
      end
      last_tap = bus_if.Tap;
      last_row = bus_if.RD_row;
      last_col = bus_if.RD_col;
      if (done_seen) begin
        bus_if.Start = noise;
        bus_if.Stall = ($urandom_range(0, 1) == 0);
        stall_prev   = 1'b0;
      end else begin
        if (armed && bus_if.RD_en === 1'b1 && bus_if.Tap == 4'd5 && cyc > 20) begin
          armed = 1'b0;
          burst = 3;
        end
        case (mode)
          1:       begin bus_if.Stall = (burst > 0); if (burst > 0) burst--; end
          2:       bus_if.Stall = ($urandom_range(0, 3) == 0);
          default: bus_if.Stall = 1'b0;
        endcase
        if (bus_if.Stall) stalls++;
        stall_prev = bus_if.Stall;
        if (noise) bus_if.Start = ($urandom_range(0, 7) == 0);
      end
    end
    check("done_seen", 32'(done_seen), 32'd1);
    @(negedge Clock);
    bus_if.Start = 1'b0;
    bus_if.Stall = 1'b0;
    check("busy_after_done", 32'(bus_if.Busy), 32'd0);
    check("done_one_cycle",  32'(bus_if.Done), 32'd0);
    @(negedge Clock);
    check("no_restart_busy", 32'(bus_if.Busy),  32'd0);
    check("no_restart_rd",   32'(bus_if.RD_en), 32'd0);
  endtask

  initial begin
    bit saw_done;
    bus_if.Start = 1'b1;
    bus_if.Stall = 1'b0;
    Resetn       = 1'b0;
    repeat (3) @(negedge Clock);
    check_all_zero("reset");
    bus_if.Start = 1'b0;
    Resetn       = 1'b1;
    repeat (2) @(negedge Clock);
    check("idle_busy", 32'(bus_if.Busy), 32'd0);

    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    for (int i = 0; i < 3; i++) run_frame(2, 1'b1);

    // Reset in the middle of a frame: outputs clear next cycle, frame abandoned.
    @(negedge Clock);
    bus_if.Start = 1'b1;
    @(negedge Clock);
    bus_if.Start = 1'b0;
    repeat (20) @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    check_all_zero("mid_reset");
    saw_done = 1'b0;
    repeat (200) begin
      @(negedge Clock);
      if (bus_if.Done === 1'b1 || bus_if.Busy === 1'b1) saw_done = 1'b1;
    end
    check("mid_reset_no_done", 32'(saw_done), 32'd0);

    run_frame(0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
